count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor.sv | 140 ++++++++++++++
 tb/tb_count_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// Watches a free-running 4-bit counter, tracks its direction and flags stalls,
// reversals, wraps and illegal jumps. Every output is registered.
module count_monitor #(
  parameter int LOCK_N = 2
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [3:0] Count,
  output logic       Dir,
  output logic       Locked,
  output logic       Stall,
  output logic       DirChange,
  output logic       WrapPulse,
  output logic       Error,
  output logic [7:0] WrapCount,
  output logic [7:0] ErrCount
);

  localparam int RW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

  typedef enum logic [2:0] {
    S_FIRST,
    S_ACQ,
    S_UP,
    S_DOWN,
    S_ERROR
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    prev;
  logic [3:0]    delta;
  logic          is_up, is_dn, is_st, is_jump, is_wrap;
  logic [RW-1:0] run, run_nxt, run_step;
  logic          run_dir, run_dir_nxt;
  logic          dir_nxt, stall_nxt, dchg_nxt, wrap_nxt, err_nxt, locked_nxt;

  always_comb begin
    delta   = Count - prev;
    is_up   = (delta == 4'd1);
    is_dn   = (delta == 4'hF);
    is_st   = (delta == 4'd0);
    is_jump = !(is_up || is_dn || is_st);
    is_wrap = (is_up && prev == 4'hF) || (is_dn && prev == 4'h0);
  end

  always_comb begin
    state_nxt   = state;
    dir_nxt     = Dir;
    run_nxt     = run;
    run_dir_nxt = run_dir;
    run_step    = '0;
    stall_nxt   = (state != S_FIRST) && is_st;
    wrap_nxt    = (state != S_FIRST) && is_wrap;
    dchg_nxt    = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      S_FIRST: state_nxt = S_ACQ;
      S_ACQ: begin
        // Jumps while acquiring are not errors: nothing has been locked yet.
        if (is_up) begin
          state_nxt = S_UP;
          dir_nxt   = 1'b1;
        end else if (is_dn) begin
          state_nxt = S_DOWN;
          dir_nxt   = 1'b0;
        end
      end
      S_UP: begin
        if (is_dn) begin
          state_nxt = S_DOWN;
          dir_nxt   = 1'b0;
          dchg_nxt  = 1'b1;
        end else if (is_jump) begin
          state_nxt = S_ERROR;
          err_nxt   = 1'b1;
          run_nxt   = '0;
        end
      end
      S_DOWN: begin
        if (is_up) begin
          state_nxt = S_UP;
          dir_nxt   = 1'b1;
          dchg_nxt  = 1'b1;
        end else if (is_jump) begin
          state_nxt = S_ERROR;
          err_nxt   = 1'b1;
          run_nxt   = '0;
        end
      end
      S_ERROR: begin
        if (is_jump) begin
          err_nxt = 1'b1;
          run_nxt = '0;
        end else if (is_up || is_dn) begin
          // A run restarts at 1 on reversal; a stall leaves it untouched.
          if (run == '0 || run_dir == is_up) run_step = run + RW'(1);
          else                               run_step = RW'(1);
          run_nxt     = run_step;
          run_dir_nxt = is_up;
          if (run_step >= RW'(LOCK_N)) begin
            state_nxt = is_up ? S_UP : S_DOWN;
            dir_nxt   = is_up;
          end
        end
      end
      default: state_nxt = S_FIRST;
    endcase
    locked_nxt = (state_nxt == S_UP) || (state_nxt == S_DOWN);
  end

  always_ff @(posedge Clk) begin
    prev <= Count;
    if (reset) begin
      state     <= S_FIRST;
      Dir       <= 1'b1;
      Locked    <= 1'b0;
      Stall     <= 1'b0;
      DirChange <= 1'b0;
      WrapPulse <= 1'b0;
      Error     <= 1'b0;
      WrapCount <= 8'd0;
      ErrCount  <= 8'd0;
      run       <= '0;
      run_dir   <= 1'b1;
    end else begin
      state     <= state_nxt;
      Dir       <= dir_nxt;
      Locked    <= locked_nxt;
      Stall     <= stall_nxt;
      DirChange <= dchg_nxt;
      WrapPulse <= wrap_nxt;
      Error     <= err_nxt;
      run       <= run_nxt;
      run_dir   <= run_dir_nxt;
      if (wrap_nxt && WrapCount != 8'hFF) WrapCount <= WrapCount + 8'd1;
      if (err_nxt && ErrCount != 8'hFF)   ErrCount  <= ErrCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: a behavioural model feeds an expected-output queue
// on every driven sample; directed checks pin down the key scenarios.
module tb_count_monitor;

  localparam int LOCK_N = 2;
  localparam int W = 22;

  logic       Clk;
  logic       reset;
  logic [3:0] Count;
  logic       Dir, Locked, Stall, DirChange, WrapPulse, Error;
  logic [7:0] WrapCount, ErrCount;

  count_monitor #(.LOCK_N(LOCK_N)) dut (
    .Clk(Clk), .reset(reset), .Count(Count),
    .Dir(Dir), .Locked(Locked), .Stall(Stall), .DirChange(DirChange),
    .WrapPulse(WrapPulse), .Error(Error), .WrapCount(WrapCount), .ErrCount(ErrCount)
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int total = 0;
  int bad = 0;
  int err_pulses = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  assign obs = {Dir, Locked, Stall, DirChange, WrapPulse, Error, WrapCount, ErrCount};

  // model state: 0 FIRST, 1 ACQ, 2 UP, 3 DOWN, 4 ERROR
  int   m_state, m_prev, m_run, m_wc, m_ec;
  logic m_dir, m_rdir, m_lock, m_stall, m_dchg, m_wrap, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int c, input logic r);
    int   d;
    logic up;
    m_stall = 0; m_dchg = 0; m_wrap = 0; m_err = 0;
    if (r) begin
      m_state = 0; m_dir = 1; m_run = 0; m_rdir = 1; m_wc = 0; m_ec = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else begin
      d = (c - m_prev + 16) % 16;
      if (d == 0) m_stall = 1;
      if ((d == 1 && m_prev == 15) || (d == 15 && m_prev == 0)) begin
        m_wrap = 1;
        if (m_wc < 255) m_wc++;
      end
      if (d == 1 || d == 15) begin
        up = (d == 1);
        if (m_state == 1) begin
          m_state = up ? 2 : 3;
          m_dir = up;
        end else if (m_state == 2 || m_state == 3) begin
          if ((m_state == 2) != up) begin
            m_dchg = 1;
            m_dir = up;
            m_state = up ? 2 : 3;
          end
        end else begin
          if (m_run > 0 && m_rdir != up) m_run = 1;
          else m_run++;
          m_rdir = up;
          if (m_run >= LOCK_N) begin
            m_state = up ? 2 : 3;
            m_dir = up;
          end
        end
      end else if (d != 0 && m_state >= 2) begin
        m_err = 1;
        if (m_ec < 255) m_ec++;
        m_run = 0;
        m_state = 4;
      end
    end
    m_lock = (m_state == 2 || m_state == 3);
    m_prev = c;
  endtask

  // driver: one sample per clock; output checked #1 after the capturing edge
  task automatic step(input int c, input logic r = 1'b0);
    @(negedge Clk);
    Count = 4'(c);
    reset = r;
    model_step(c, r);
    exp_q.push_back({m_dir, m_lock, m_stall, m_dchg, m_wrap, m_err, 8'(m_wc), 8'(m_ec)});
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) check("queue_empty", 1, 0);
    else check("scoreboard", obs, exp_q.pop_front());
    if (Error === 1'b1) err_pulses++;
  endtask

  initial begin
    int c, kind;
    reset = 1'b1;
    Count = 4'd0;

    // reset values
    step(0, 1);
    step(0, 1);
    check("rst_vec", obs, 22'h200000);

    // 0..15,0,1 counting up
    err_pulses = 0;
    step(0);
    step(1);
    check("lock_up", Locked, 1);
    for (int i = 2; i < 16; i++) step(i);
    step(0);
    check("wrap_15_0", WrapPulse, 1);
    step(1);
    check("wrap_once", WrapPulse, 0);
    check("wrapcount1", WrapCount, 1);
    check("dir_up", Dir, 1);
    check("no_error", err_pulses, 0);

    // reversal while locked up at 5
    for (int i = 2; i <= 5; i++) step(i);
    step(4);
    check("dchg_5_4", DirChange, 1);
    check("dir_down", Dir, 0);
    check("lock_keep", Locked, 1);
    step(3);
    check("dchg_pulse", DirChange, 0);

    // jump and relock
    step(0, 1);
    step(0); step(1); step(2); step(3);
    step(9);
    check("jump_err", Error, 1);
    check("jump_unlock", Locked, 0);
    check("errcount1", ErrCount, 1);
    step(10);
    check("relock_wait", Locked, 0);
    step(11);
    check("relock", Locked, 1);
    check("relock_dir", Dir, 1);
    check("relock_nodchg", DirChange, 0);

    // stalls while locked down
    step(10); step(9); step(8); step(7);
    step(7);
    check("stall1", Stall, 1);
    step(7);
    check("stall2", Stall, 1);
    check("stall_lock", Locked, 1);
    step(6);
    check("stall_end", Stall, 0);
    check("stall_dir", Dir, 0);
    check("stall_noerr", Error, 0);

    // saturation then reset mid-ERROR
    c = 6;
    for (int i = 0; i < 300; i++) begin
      c = c ^ 8;
      step(c);
    end
    check("errsat", ErrCount, 255);
    step(c, 1);
    check("rst_mid_err", obs, 22'h200000);

    // reversal at 15 (no wrap), later 0->15 wrap
    step(12); step(13); step(14); step(15);
    step(14);
    check("dchg_15_14", DirChange, 1);
    check("nowrap_15_14", WrapPulse, 0);
    for (int i = 13; i >= 0; i--) step(i);
    step(15);
    check("wrap_0_15", WrapPulse, 1);
    check("wrap_0_15_nodchg", DirChange, 0);
    check("wrapcount_dn", WrapCount, 1);

    // wrap while acquiring
    step(0, 1);
    step(15);
    step(0);
    check("acq_wrap", WrapPulse, 1);

    // random walk with stalls, jumps and occasional reset
    c = 0;
    for (int i = 0; i < 500; i++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 3)      c = (c + 1) % 16;
      else if (kind <= 6) c = (c + 15) % 16;
      else if (kind == 8) c = $urandom_range(0, 15);
      step(c, $urandom_range(0, 99) < 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
